// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte sources.
// Round-robin selection with an optional per-byte ownership lock, a one-cycle
// launch strobe, done-edge tracking and a launch-to-done abort timer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame in flight; select once transmitter is quiet
// LAUNCH    | o_Tx_DV and o_Ack pulse for the winner this cycle
// WAIT_DONE | frame in flight; wait for rising i_Tx_Done or timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 2048
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Lock,
  output logic [NUM_REQ-1:0]   o_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_RST     = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 lock_q, lock_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q;
  logic                 done_rise;

  logic [NUM_REQ-1:0]   ack_d, grant_d;
  logic                 dv_d, busy_d, timeout_d;
  logic [7:0]           byte_d;

  logic                 found;
  logic [PTR_W-1:0]     sel_idx;
  logic [PTR_W-1:0]     cand;
  int                   idx;

  // Done is edge-qualified so a stretched done pulse completes one frame only.
  assign done_rise = i_Tx_Done & ~done_q;

  // Winner search: a locked owner that still requests keeps the transmitter,
  // otherwise the first requester after the last winner, wrapping around.
  always_comb begin
    found   = 1'b0;
    sel_idx = ptr_q;
    idx     = 0;
    cand    = '0;
    if (lock_q && i_Req[ptr_q]) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx  = (int'(ptr_q) + k) % NUM_REQ;
        cand = PTR_W'(idx);
        if (!found && i_Req[cand]) begin
          found   = 1'b1;
          sel_idx = cand;
        end
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    dv_d      = 1'b0;
    timeout_d = 1'b0;
    grant_d   = o_Grant;
    byte_d    = o_Tx_Byte;
    case (state_q)
      IDLE: begin
        // A lock whose owner has gone quiet is released before arbitrating.
        if (lock_q && !i_Req[ptr_q]) lock_d = 1'b0;
        if (found && !i_Tx_Active && !i_Tx_Done) begin
          state_d          = LAUNCH;
          ptr_d            = sel_idx;
          lock_d           = i_Req_Lock[sel_idx];
          byte_d           = i_Req_Byte[{sel_idx, 3'b000} +: 8];
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          ack_d[sel_idx]   = 1'b1;
          dv_d             = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        // A done edge in the same cycle as expiry counts as a normal finish.
        if (done_rise) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (cnt_q + CNT_ONE == TIMEOUT_CNT) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
          lock_d    = 1'b0;
          cnt_d     = TIMEOUT_CNT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, arbitration context and registered outputs.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      o_Ack     <= '0;
      o_Grant   <= '0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
      o_Busy    <= 1'b0;
      o_Timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      o_Ack     <= ack_d;
      o_Grant   <= grant_d;
      o_Tx_DV   <= dv_d;
      o_Tx_Byte <= byte_d;
      o_Busy    <= busy_d;
      o_Timeout <= timeout_d;
    end
  end

  // Previous-cycle copy of i_Tx_Done for edge detection.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) done_q <= 1'b0;
    else            done_q <= i_Tx_Done;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 2048, max clocks from launch to transmitter done before abort.
REQ-003 SHALL have port i_Clock  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_Reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_Req  in  NUM_REQ  per-requester byte-valid.
REQ-006 SHALL have port i_Req_Byte  in  8*NUM_REQ  requester k byte at bits [8k+7:8k].
REQ-007 SHALL have port i_Req_Lock  in  NUM_REQ  requester k keeps ownership after the current byte.
REQ-008 SHALL have port o_Ack  out  NUM_REQ  one-cycle pulse, byte of requester k accepted.
REQ-009 SHALL have port o_Grant  out  NUM_REQ  one-hot current owner, zero when idle.
REQ-010 SHALL have port o_Tx_DV  out  1  one-cycle launch strobe to transmitter.
REQ-011 SHALL have port o_Tx_Byte  out  8  byte to transmitter, registered.
REQ-012 SHALL have ports i_Tx_Active  in  1 and i_Tx_Done  in  1  transmitter status.
REQ-013 SHALL have ports o_Busy  out  1 (state not IDLE) and o_Timeout  out  1 (one-cycle abort pulse).

Function
REQ-014 SHALL implement states IDLE, LAUNCH, WAIT_DONE; all outputs registered.
REQ-015 IDLE: SHALL select only when any i_Req=1, i_Tx_Active=0 and i_Tx_Done=0; else stay IDLE.
REQ-016 Selection SHALL be round-robin: search indices ptr+1, ptr+2, ... modulo NUM_REQ, first i_Req=1 wins; ptr becomes winner.
REQ-017 If lock flag set and i_Req[ptr]=1, SHALL select ptr regardless of others; if lock set and i_Req[ptr]=0, SHALL clear lock and arbitrate normally in the same cycle.
REQ-018 On selection (IDLE->LAUNCH), SHALL capture winner byte into o_Tx_Byte, set o_Grant one-hot, latch lock flag = i_Req_Lock[winner].
REQ-019 LAUNCH: SHALL assert o_Tx_DV=1 and o_Ack[winner]=1 for exactly this one cycle, then go WAIT_DONE.
REQ-020 Latency SHALL be 1 clock: request seen in IDLE at edge N -> o_Tx_DV/o_Ack high during cycle N+1.
REQ-021 Requester SHALL hold i_Req/byte stable until o_Ack; a new byte may be presented the cycle after o_Ack.
REQ-022 WAIT_DONE: SHALL detect rising edge of i_Tx_Done (multi-cycle done high counts once) and return to IDLE, clearing o_Grant.
REQ-023 Timeout counter SHALL clear on LAUNCH, increment each WAIT_DONE cycle; on reaching TIMEOUT_CLKS without done edge SHALL pulse o_Timeout, clear lock, return to IDLE.
REQ-024 Counter width SHALL be clog2(TIMEOUT_CLKS+1), no wrap.
REQ-025 Simultaneous done edge and timeout SHALL be treated as done (no o_Timeout).
REQ-026 o_Ack SHALL never assert for a requester whose i_Req was low at selection; at most one o_Ack bit high per cycle.

Reset
REQ-027 Reset low SHALL immediately force IDLE; o_Ack, o_Grant, o_Tx_DV, o_Busy, o_Timeout, o_Tx_Byte=0; lock clear; counter 0; ptr=NUM_REQ-1 (requester 0 first priority).
REQ-028 Reset mid-frame SHALL not launch again until i_Tx_Active=0 and i_Tx_Done=0 (transmitter is not reset by this block).

Verification
REQ-029 Single: i_Req=0001, byte 0xA5 -> next cycle o_Tx_DV=1, o_Tx_Byte=0xA5, o_Ack=0001, o_Grant=0001; no further DV until done edge.
REQ-030 Fairness: i_Req=1111 held, bytes 0x10/0x11/0x12/0x13 -> launch order 0,1,2,3,0 after reset.
REQ-031 Lock: req 1 with lock=1 for 3 bytes while req 2 pending -> three launches to 1, then lock low -> next launch to 2.
REQ-032 Done stretch: i_Tx_Done high 2 cycles -> exactly one return to IDLE; relaunch only after done low.
REQ-033 Timeout: TIMEOUT_CLKS=16, no done -> o_Timeout pulse 16 cycles after LAUNCH, o_Grant=0, then next request served.
REQ-034 Reset during WAIT_DONE with i_Tx_Active=1 -> outputs 0 immediately; no o_Tx_DV until i_Tx_Active falls.
